// File: rtl/csr_read_master_pkg.sv
// Shared CSR map and STATUS layout for the CSR-controlled Avalon-MM read master.
package csr_read_master_pkg;

  localparam logic [3:0] CSR_CONTROL = 4'd0;
  localparam logic [3:0] CSR_STATUS  = 4'd1;
  localparam logic [3:0] CSR_LENGTH  = 4'd2;
  localparam logic [3:0] CSR_BASE    = 4'd3;
  localparam logic [3:0] CSR_DATA    = 4'd4;
  localparam logic [3:0] CSR_POP     = 4'd5;

  localparam int CTRL_GO    = 0;
  localparam int CTRL_FIXED = 1;

  localparam int ST_DONE  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_USED  = 8;

endpackage

// File: rtl/sync_fifo_showahead.sv
// Single-clock show-ahead FIFO: dout always presents the head word, pop advances it.
module sync_fifo_showahead #(
  parameter int DATAWIDTH = 32,
  parameter int FIFODEPTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATAWIDTH-1:0]         din,
  output logic [DATAWIDTH-1:0]         dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFODEPTH):0]   used
);
  localparam int AW = $clog2(FIFODEPTH);

  logic [DATAWIDTH-1:0] mem_q [FIFODEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [AW:0]          used_q;
  logic                 do_push, do_pop;

  assign empty   = (used_q == '0);
  assign full    = (used_q == (AW+1)'(FIFODEPTH));
  assign used    = used_q;
  assign dout    = mem_q[rp_q];
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO only lands if the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      used_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   used_q <= used_q + (AW+1)'(1);
        2'b01:   used_q <= used_q - (AW+1)'(1);
        default: used_q <= used_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end

endmodule

// File: rtl/csr_read_master.sv
// Avalon-MM pipelined read master: host programs BASE/LENGTH and pulses go; returned
// words land in a show-ahead FIFO that the host drains one word per POP write.
module csr_read_master
  import csr_read_master_pkg::*;
#(
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int ADDRESSWIDTH    = 32,
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTH_LOG2  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 avs_csr_address,
  input  logic                       avs_csr_write,
  input  logic [31:0]                avs_csr_writedata,
  output logic [31:0]                avs_csr_readdata,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_read,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  input  logic [DATAWIDTH-1:0]       master_readdata,
  input  logic                       master_readdatavalid,
  input  logic                       master_waitrequest
);
  localparam int          CW    = FIFODEPTH_LOG2 + 1;
  localparam logic [31:0] WMASK = ~32'(BYTEENABLEWIDTH - 1);

  logic [31:0]             length_q, base_q, status_q, status_d;
  logic [31:0]             remain_q, remain_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]           pend_q, pend_d;
  logic                    fixed_q, fixed_d;

  logic                    wr_ctrl, wr_length, wr_base, pop_req;
  logic                    busy, go_acc, issue, ret;
  logic [CW:0]             inflight;

  logic [DATAWIDTH-1:0]    fifo_dout;
  logic                    fifo_empty, fifo_full;
  logic [CW-1:0]           fifo_used;

  assign wr_ctrl   = avs_csr_write && (avs_csr_address == CSR_CONTROL);
  assign wr_length = avs_csr_write && (avs_csr_address == CSR_LENGTH);
  assign wr_base   = avs_csr_write && (avs_csr_address == CSR_BASE);
  assign pop_req   = avs_csr_write && (avs_csr_address == CSR_POP) && avs_csr_writedata[0];

  assign busy   = (remain_q != '0) || (pend_q != '0);
  assign go_acc = wr_ctrl && avs_csr_writedata[CTRL_GO] && !busy;

  // Credit check: words already held plus words still in flight never exceed the
  // FIFO, so a return always finds room.
  assign inflight    = {1'b0, fifo_used} + {1'b0, pend_q};
  assign master_read = (remain_q != '0) && (inflight < (CW+1)'(FIFODEPTH));

  assign issue = master_read && !master_waitrequest;
  assign ret   = master_readdatavalid && (pend_q != '0);

  assign master_address    = addr_q;
  assign master_byteenable = '1;

  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    pend_d   = pend_q;
    fixed_d  = fixed_q;
    if (go_acc) begin
      addr_d   = ADDRESSWIDTH'(base_q);
      remain_d = length_q;
      fixed_d  = avs_csr_writedata[CTRL_FIXED];
    end else if (issue) begin
      remain_d = remain_q - 32'(BYTEENABLEWIDTH);
      if (!fixed_q) addr_d = addr_q + ADDRESSWIDTH'(BYTEENABLEWIDTH);
    end
    case ({issue, ret})
      2'b10:   pend_d = pend_q + CW'(1);
      2'b01:   pend_d = pend_q - CW'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_comb begin
    status_d                = '0;
    status_d[ST_DONE]       = !busy;
    status_d[ST_EMPTY]      = fifo_empty;
    status_d[ST_FULL]       = fifo_full;
    status_d[ST_BUSY]       = busy;
    status_d[ST_USED +: CW] = fifo_used;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      remain_q <= '0;
      pend_q   <= '0;
      fixed_q  <= 1'b0;
      length_q <= '0;
      base_q   <= '0;
      status_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
      pend_q   <= pend_d;
      fixed_q  <= fixed_d;
      status_q <= status_d;
      if (wr_length) length_q <= avs_csr_writedata & WMASK;
      if (wr_base)   base_q   <= avs_csr_writedata & WMASK;
    end
  end

  always_comb begin
    case (avs_csr_address)
      CSR_LENGTH: avs_csr_readdata = length_q;
      CSR_BASE:   avs_csr_readdata = base_q;
      CSR_DATA:   avs_csr_readdata = fifo_empty ? 32'h0 : 32'(fifo_dout);
      default:    avs_csr_readdata = status_q;
    endcase
  end

  sync_fifo_showahead #(
    .DATAWIDTH (DATAWIDTH),
    .FIFODEPTH (FIFODEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ret),
    .pop   (pop_req),
    .din   (master_readdata),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .used  (fifo_used)
  );

endmodule

// File: tb/tb_csr_read_master.sv
// Bench for csr_read_master: behavioural Avalon slave with random stalls/latency,
// expected words computed from the address sequence implied by BASE/LENGTH/fixed.
module tb_csr_read_master;
  localparam int FD = 4, FDL = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic [3:0]  avs_csr_address = '0;
  logic        avs_csr_write = 1'b0;
  logic [31:0] avs_csr_writedata = '0, avs_csr_readdata;
  logic [31:0] master_address, master_readdata = '0;
  logic        master_read, master_readdatavalid = 1'b0, master_waitrequest = 1'b0;
  logic [3:0]  master_byteenable;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  csr_read_master #(.DATAWIDTH(32), .BYTEENABLEWIDTH(4), .ADDRESSWIDTH(32),
                    .FIFODEPTH(FD), .FIFODEPTH_LOG2(FDL)) dut (
    .clk(clk), .reset(reset),
    .avs_csr_address(avs_csr_address), .avs_csr_write(avs_csr_write),
    .avs_csr_writedata(avs_csr_writedata), .avs_csr_readdata(avs_csr_readdata),
    .master_address(master_address), .master_read(master_read),
    .master_byteenable(master_byteenable), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_waitrequest(master_waitrequest));

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hC0DE_1234;
  endfunction

  // ---------------- slave model ----------------
  typedef struct packed { logic [31:0] due; logic [31:0] data; } rsp_t;
  rsp_t        rq[$];
  logic [31:0] acc_addr[$];
  logic [31:0] exp_q[$];
  int wait_pct = 0, lat_min = 1, lat_max = 1, stall_idx = -1, stall_left = 0;
  int acc_cnt = 0, stab_err = 0, cyc = 0, last_due = 0, due = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  // Everything here describes what the DUT will see at the coming posedge.
  always @(negedge clk) begin
    cyc++;
    if (prev_stall && !reset && (!master_read || master_address !== prev_addr)) stab_err++;
    if (rq.size() > 0 && rq[0].due <= 32'(cyc)) begin
      master_readdatavalid = 1'b1;
      master_readdata      = rq[0].data;
      void'(rq.pop_front());
    end else begin
      master_readdatavalid = 1'b0;
      master_readdata      = $urandom;
    end
    if (master_read && acc_cnt == stall_idx && stall_left > 0) begin
      master_waitrequest = 1'b1;
      stall_left--;
    end else begin
      master_waitrequest = ($urandom_range(0, 99) < wait_pct);
    end
    prev_stall = master_read && master_waitrequest;
    prev_addr  = master_address;
    if (master_read && !master_waitrequest) begin
      acc_cnt++;
      acc_addr.push_back(master_address);
      due = cyc + int'($urandom_range(lat_min, lat_max));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq.push_back('{32'(due), memf(master_address)});
    end
  end

  always begin
    @(negedge clk); #4;
    if (!reset && dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop) begin
      errors++;
      $display("FAIL fifo_overflow: push into full fifo at cycle %0d", cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- host helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    avs_csr_address = a; avs_csr_writedata = d; avs_csr_write = 1'b1;
    @(negedge clk);
    avs_csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    avs_csr_address = a;
    #1 d = avs_csr_readdata;
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] len, input bit fixed);
    logic [31:0] b;
    int n;
    b = base & 32'hFFFF_FFFC;
    n = int'(len >> 2);
    exp_q.delete();
    acc_addr.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(fixed ? b : b + 32'(4 * i));
    csr_wr(4'd3, base);
    csr_wr(4'd2, len);
    csr_wr(4'd0, fixed ? 32'h3 : 32'h1);
  endtask

  // Pops words first..end, checking each against the model, then checks idle status
  // and the full address sequence seen by the slave.
  task automatic drain(input int first, input int gap, input string tag);
    logic [31:0] d;
    int to;
    for (int i = first; i < exp_q.size(); i++) begin
      to = 0;
      do begin tick(1); csr_rd(4'd1, d); to++; end while (d[1] && to < 300);
      checks++;
      if (d[1]) begin
        errors++;
        $display("FAIL %s_wait word %0d: fifo still empty after %0d cycles, need a word", tag, i, to);
        return;
      end
      csr_rd(4'd4, d);
      checks++;
      if (d !== memf(exp_q[i])) begin
        errors++;
        $display("FAIL %s_data word %0d: got %h need %h", tag, i, d, memf(exp_q[i]));
      end
      csr_wr(4'd5, 32'h1);
      if (gap > 0) tick($urandom_range(0, gap));
    end
    to = 0;
    do begin tick(1); csr_rd(4'd1, d); to++; end while (!d[0] && to < 300);
    checks++;
    if (d !== 32'h3) begin
      errors++; $display("FAIL %s_status_end: got %h need 00000003", tag, d);
    end
    checks++;
    if (acc_addr.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_nreads: got %0d need %0d", tag, acc_addr.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (acc_addr[i] !== exp_q[i]) begin
          errors++; $display("FAIL %s_addr %0d: got %h need %h", tag, i, acc_addr[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL %s_stable: %0d request changes under waitrequest, need 0", tag, stab_err);
      stab_err = 0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    tick(2);
    csr_rd(4'd1, d);
    checks++;
    if ({master_read, master_address, master_byteenable, d} !== {1'b0, 32'h0, 4'hF, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b addr=%h be=%h csr=%h need 0/0/f/0",
               master_read, master_address, master_byteenable, d);
    end
    reset = 1'b0;
    tick(2);
    csr_rd(4'd1, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL reset_status: got %h need 00000003", d); end
  endtask

  task automatic test_csr_regs();
    logic [31:0] d;
    csr_wr(4'd2, 32'hFFFF_FFFF); csr_rd(4'd2, d);
    checks++;
    if (d !== 32'hFFFF_FFFC) begin errors++; $display("FAIL length_mask: got %h need fffffffc", d); end
    csr_wr(4'd3, 32'h1234_5677); csr_rd(4'd3, d);
    checks++;
    if (d !== 32'h1234_5674) begin errors++; $display("FAIL base_mask: got %h need 12345674", d); end
    csr_wr(4'd2, 32'h0);
    csr_wr(4'd5, 32'h1);
    tick(2);
    csr_rd(4'd7, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL other_offset/pop_empty: got %h need 00000003", d); end
    csr_rd(4'd4, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL data_empty: got %h need 00000000", d); end
  endtask

  task automatic test_basic();
    wait_pct = 0; lat_min = 1; lat_max = 1;
    start(32'h100, 32'd16, 1'b0);
    drain(0, 0, "basic");
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    int a0;
    wait_pct = 0; lat_min = 2; lat_max = 2;
    a0 = acc_cnt;
    start(32'h300, 32'd32, 1'b0);
    tick(20);
    checks++;
    if (acc_cnt - a0 != FD || master_read !== 1'b0) begin
      errors++; $display("FAIL bp_stall: reads=%0d read=%b need %0d/0", acc_cnt - a0, master_read, FD);
    end
    csr_rd(4'd1, d);
    checks++;
    if (d !== 32'h40C) begin errors++; $display("FAIL bp_status: got %h need 0000040c", d); end
    csr_rd(4'd4, d);
    checks++;
    if (d !== memf(32'h300)) begin errors++; $display("FAIL bp_head: got %h need %h", d, memf(32'h300)); end
    csr_wr(4'd5, 32'h1);
    tick(20);
    checks++;
    if (acc_cnt - a0 != FD + 1) begin
      errors++; $display("FAIL bp_one_more: reads=%0d need %0d", acc_cnt - a0, FD + 1);
    end
    drain(1, 0, "bp");
  endtask

  task automatic test_waitrequest();
    wait_pct = 0; lat_min = 3; lat_max = 3;
    stall_idx = acc_cnt + 1; stall_left = 5;
    start(32'h500, 32'd20, 1'b0);
    drain(0, 1, "wait");
    checks++;
    if (stall_left != 0) begin errors++; $display("FAIL wait_applied: %0d stall cycles left, need 0", stall_left); end
    stall_idx = -1;
  endtask

  task automatic test_fixed();
    wait_pct = 20; lat_min = 1; lat_max = 3;
    start(32'h40, 32'd12, 1'b1);
    drain(0, 0, "fixed");
  endtask

  task automatic test_zero_and_busy_go();
    logic [31:0] d;
    int a0;
    wait_pct = 0; lat_min = 1; lat_max = 2;
    a0 = acc_cnt;
    start(32'h600, 32'd0, 1'b0);
    tick(5);
    csr_rd(4'd1, d);
    checks++;
    if (acc_cnt != a0 || d !== 32'h3) begin
      errors++; $display("FAIL zero_len: reads=%0d status=%h need 0/00000003", acc_cnt - a0, d);
    end
    start(32'h700, 32'd32, 1'b0);
    tick(10);
    csr_wr(4'd3, 32'h900); csr_wr(4'd2, 32'd8); csr_wr(4'd0, 32'h1);
    drain(0, 2, "busy_go");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int a0, to;
    wait_pct = 0; lat_min = 8; lat_max = 8;
    a0 = acc_cnt;
    start(32'hA00, 32'd16, 1'b0);
    to = 0;
    do begin tick(1); #1; to++; end while (acc_cnt - a0 < 3 && to < 50);
    reset = 1'b1;
    csr_rd(4'd1, d);
    checks++;
    if ({master_read, master_address, master_byteenable, d} !== {1'b0, 32'h0, 4'hF, 32'h0}) begin
      errors++;
      $display("FAIL midreset_outputs: rd=%b addr=%h be=%h csr=%h need 0/0/f/0",
               master_read, master_address, master_byteenable, d);
    end
    tick(2);
    reset = 1'b0;
    a0 = acc_cnt;
    tick(20);
    csr_rd(4'd1, d);
    checks++;
    if (d !== 32'h3 || acc_cnt != a0) begin
      errors++; $display("FAIL midreset_stale: status=%h reads=%0d need 00000003/0", d, acc_cnt - a0);
    end
    csr_rd(4'd4, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h need 00000000", d); end
  endtask

  task automatic test_wrap();
    wait_pct = 10; lat_min = 1; lat_max = 2;
    start(32'hFFFF_FFF8, 32'd16, 1'b0);
    drain(0, 0, "wrap");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      wait_pct = $urandom_range(0, 40);
      lat_min  = 1;
      lat_max  = $urandom_range(1, 6);
      start($urandom, 32'($urandom_range(0, 44)), $urandom_range(0, 3) == 0);
      drain(0, $urandom_range(0, 4), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_csr_regs();
    test_basic();
    test_backpressure();
    test_waitrequest();
    test_fixed();
    test_zero_and_busy_go();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
